// File: rtl/serial_parity_checker.sv
// serial_parity_checker: frames FRAME_LEN serial data bits plus one even-parity
// bit, publishes the assembled word and a per-frame parity error flag.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      synchronous active-low reset
//   start      opens a frame (honoured only when idle)
//   bit_in     serial data bit
//   bit_valid  bit_in accepted on this edge when high
//   busy       a frame is open
//   data_out   last completed data word, MSB = first bit received
//   frame_done one-cycle pulse after the parity bit is accepted
//   parity_err 1 = last completed frame had a parity mismatch
//   err_count  saturating count of bad frames
//
// Build option: PARITY_ERR_COUNT_EN builds the error counter; when undefined
// err_count is tied to zero and no counter flops exist.
module serial_parity_checker #(
    parameter int FRAME_LEN = 8,
    parameter int CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic                 busy,
    output logic [FRAME_LEN-1:0] data_out,
    output logic                 frame_done,
    output logic                 parity_err,
    output logic [CNT_W-1:0]     err_count
);

    localparam int CW = $clog2(FRAME_LEN);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t               state, state_d;
    logic [CW-1:0]        cnt, cnt_d;
    logic [FRAME_LEN-1:0] sh, sh_d;
    logic                 acc, acc_d;
    logic [FRAME_LEN-1:0] dout_d;
    logic                 perr_d;
    logic                 done_d;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        sh_d    = sh;
        acc_d   = acc;
        dout_d  = data_out;
        perr_d  = parity_err;
        done_d  = 1'b0;
        unique case (state)
            IDLE: begin
                // bit_valid is deliberately ignored here, even alongside start
                if (start) begin
                    state_d = DATA;
                    cnt_d   = '0;
                    sh_d    = '0;
                    acc_d   = 1'b0;
                end
            end
            DATA: begin
                if (bit_valid) begin
                    sh_d  = {sh[FRAME_LEN-2:0], bit_in};
                    acc_d = acc ^ bit_in;
                    cnt_d = cnt + CW'(1);
                    if (cnt == CW'(FRAME_LEN - 1)) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (bit_valid) begin
                    perr_d  = acc ^ bit_in;
                    dout_d  = sh;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            sh         <= '0;
            acc        <= 1'b0;
            data_out   <= '0;
            parity_err <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_d;
            cnt        <= cnt_d;
            sh         <= sh_d;
            acc        <= acc_d;
            data_out   <= dout_d;
            parity_err <= perr_d;
            frame_done <= done_d;
            // busy drops in the same cycle frame_done rises
            busy       <= (state_d != IDLE);
        end
    end

`ifdef PARITY_ERR_COUNT_EN
    logic [CNT_W-1:0] ecnt;
    logic             bad;

    assign bad = (state == PARITY) && bit_valid && (acc ^ bit_in);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ecnt <= '0;
        end else if (bad && (ecnt != '1)) begin
            ecnt <= ecnt + CNT_W'(1);
        end
    end

    assign err_count = ecnt;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_serial_parity_checker.sv
// tb_serial_parity_checker: scoreboard bench for serial_parity_checker.
// Expected frame results are queued as parity bits are driven.
module tb_serial_parity_checker;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       bit_in;
    logic       bit_valid;
    logic       busy;
    logic [7:0] data_out;
    logic       frame_done;
    logic       parity_err;
    logic [7:0] err_count;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic [7:0] ec;
    } exp_t;

    exp_t       q[$];
    logic [7:0] exp_ec;
    int         checks;
    int         errors;

    serial_parity_checker #(.FRAME_LEN(8), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bit_in    (bit_in),
        .bit_valid (bit_valid),
        .busy      (busy),
        .data_out  (data_out),
        .frame_done(frame_done),
        .parity_err(parity_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one frame; bit_valid is high alongside start and must be ignored.
    task automatic drive_frame(input logic [7:0] d, input logic p,
                               input int stall_at, input int stall_n,
                               input int pstall, input bit restart);
        exp_t e;
        start     = 1'b1;
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            bit_in    = d[i];
            bit_valid = 1'b1;
            tick();
            if (8 - i == stall_at) begin
                for (int k = 0; k < stall_n; k++) begin
                    bit_valid = 1'b0;
                    bit_in    = ~bit_in;
                    start     = restart && (k == 0);
                    tick();
                    start = 1'b0;
                end
            end
        end
        for (int k = 0; k < pstall; k++) begin
            bit_valid = 1'b0;
            bit_in    = ~p;
            tick();
        end
        e.d  = d;
        e.pe = (^d) ^ p;
`ifdef PARITY_ERR_COUNT_EN
        if (e.pe && exp_ec != 8'hFF) exp_ec = exp_ec + 8'd1;
`endif
        e.ec = exp_ec;
        q.push_back(e);
        bit_in    = p;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic collect(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            bit_valid = 1'b0;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        checks += 5;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got=%b want=0", busy);
        end
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got=%b want=0", frame_done);
        end
        if (parity_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_perr got=%b want=0", parity_err);
        end
        if (data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_data got=%h want=00", data_out);
        end
        if (err_count !== 8'h00) begin
            errors++;
            $display("FAIL reset_ecnt got=%0d want=0", err_count);
        end
        rst_n = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got=%b want=0", busy);
        end
    endtask

    task automatic test_basic();
        bit   ok;
        exp_t e;
        drive_frame(8'hA5, 1'b0, 0, 0, 0, 1'b0);
        collect(ok);
        checks++;
        if (!ok || q.size() == 0) begin
            errors++;
            $display("FAIL basic_done got=%b want=1", frame_done);
        end else begin
            e = q.pop_front();
            checks += 4;
            if (data_out !== e.d) begin
                errors++;
                $display("FAIL basic_data got=%h want=%h", data_out, e.d);
            end
            if (parity_err !== e.pe) begin
                errors++;
                $display("FAIL basic_perr got=%b want=%b", parity_err, e.pe);
            end
            if (err_count !== e.ec) begin
                errors++;
                $display("FAIL basic_ecnt got=%0d want=%0d", err_count, e.ec);
            end
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy got=%b want=0", busy);
            end
        end
        tick();
        checks += 2;
        if (frame_done !== 1'b0) begin
            errors++;
            $display("FAIL basic_pulse got=%b want=0", frame_done);
        end
        if (data_out !== 8'hA5) begin
            errors++;
            $display("FAIL basic_hold got=%h want=a5", data_out);
        end
    endtask

    task automatic test_bad_parity();
        bit   ok;
        exp_t e;
        drive_frame(8'hA5, 1'b1, 0, 0, 0, 1'b0);
        collect(ok);
        checks++;
        if (!ok || q.size() == 0) begin
            errors++;
            $display("FAIL bad_done got=%b want=1", frame_done);
        end else begin
            e = q.pop_front();
            checks += 3;
            if (data_out !== e.d) begin
                errors++;
                $display("FAIL bad_data got=%h want=%h", data_out, e.d);
            end
            if (parity_err !== e.pe) begin
                errors++;
                $display("FAIL bad_perr got=%b want=%b", parity_err, e.pe);
            end
            if (err_count !== e.ec) begin
                errors++;
                $display("FAIL bad_ecnt got=%0d want=%0d", err_count, e.ec);
            end
        end
        tick();
    endtask

    task automatic test_stall();
        bit   ok;
        exp_t e;
        drive_frame(8'h01, 1'b1, 3, 3, 2, 1'b0);
        checks++;
        if (frame_done !== 1'b1) begin
            errors++;
            $display("FAIL stall_latency got=%b want=1", frame_done);
        end
        collect(ok);
        checks++;
        if (!ok || q.size() == 0) begin
            errors++;
            $display("FAIL stall_done got=%b want=1", frame_done);
        end else begin
            e = q.pop_front();
            checks += 3;
            if (data_out !== e.d) begin
                errors++;
                $display("FAIL stall_data got=%h want=%h", data_out, e.d);
            end
            if (parity_err !== e.pe) begin
                errors++;
                $display("FAIL stall_perr got=%b want=%b", parity_err, e.pe);
            end
            if (err_count !== e.ec) begin
                errors++;
                $display("FAIL stall_ecnt got=%0d want=%0d", err_count, e.ec);
            end
        end
        tick();
    endtask

    task automatic test_start_busy();
        bit   ok;
        exp_t e;
        drive_frame(8'hFF, 1'b0, 4, 1, 0, 1'b1);
        collect(ok);
        checks++;
        if (!ok || q.size() == 0) begin
            errors++;
            $display("FAIL restart_done got=%b want=1", frame_done);
        end else begin
            e = q.pop_front();
            checks += 2;
            if (data_out !== e.d) begin
                errors++;
                $display("FAIL restart_data got=%h want=%h", data_out, e.d);
            end
            if (parity_err !== e.pe) begin
                errors++;
                $display("FAIL restart_perr got=%b want=%b", parity_err, e.pe);
            end
        end
        tick();
    endtask

    task automatic test_reset_mid();
        bit   ok;
        exp_t e;
        logic [7:0] d;
        d     = 8'hC3;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy got=%b want=1", busy);
        end
        for (int i = 7; i >= 3; i--) begin
            bit_in    = d[i];
            bit_valid = 1'b1;
            tick();
        end
        rst_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            bit_in = d[2 - k];
            tick();
            checks += 4;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_ctl got=%b%b want=00", frame_done, busy);
            end
            if (data_out !== 8'h00) begin
                errors++;
                $display("FAIL mid_rst_data got=%h want=00", data_out);
            end
            if (parity_err !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_perr got=%b want=0", parity_err);
            end
            if (err_count !== 8'h00) begin
                errors++;
                $display("FAIL mid_rst_ecnt got=%0d want=0", err_count);
            end
        end
        rst_n     = 1'b1;
        bit_valid = 1'b0;
        exp_ec    = 8'h00;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (frame_done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL mid_abort got=%b%b want=00", frame_done, busy);
            end
        end
        drive_frame(8'h3C, 1'b0, 0, 0, 0, 1'b0);
        collect(ok);
        checks++;
        if (!ok || q.size() == 0) begin
            errors++;
            $display("FAIL mid_done got=%b want=1", frame_done);
        end else begin
            e = q.pop_front();
            checks += 3;
            if (data_out !== e.d) begin
                errors++;
                $display("FAIL mid_data got=%h want=%h", data_out, e.d);
            end
            if (parity_err !== e.pe) begin
                errors++;
                $display("FAIL mid_perr got=%b want=%b", parity_err, e.pe);
            end
            if (err_count !== e.ec) begin
                errors++;
                $display("FAIL mid_ecnt got=%0d want=%0d", err_count, e.ec);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit         ok;
        exp_t       e;
        logic [7:0] d;
        logic [7:0] sat;
`ifdef PARITY_ERR_COUNT_EN
        sat = 8'd255;
`else
        sat = 8'd0;
`endif
        for (int n = 0; n < 257; n++) begin
            d = 8'($urandom_range(0, 255));
            drive_frame(d, ~(^d), 0, 0, 0, 1'b0);
            collect(ok);
            checks++;
            if (!ok || q.size() == 0) begin
                errors++;
                $display("FAIL b2b_done n=%0d got=%b want=1", n, frame_done);
            end else begin
                e = q.pop_front();
                checks += 3;
                if (data_out !== e.d) begin
                    errors++;
                    $display("FAIL b2b_data n=%0d got=%h want=%h", n, data_out, e.d);
                end
                if (parity_err !== e.pe) begin
                    errors++;
                    $display("FAIL b2b_perr n=%0d got=%b want=%b", n, parity_err, e.pe);
                end
                if (err_count !== e.ec) begin
                    errors++;
                    $display("FAIL b2b_ecnt n=%0d got=%0d want=%0d", n, err_count, e.ec);
                end
            end
        end
        tick();
        checks++;
        if (err_count !== sat) begin
            errors++;
            $display("FAIL sat_ecnt got=%0d want=%0d", err_count, sat);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        exp_ec    = 8'h00;
        rst_n     = 1'b0;
        start     = 1'b0;
        bit_in    = 1'b0;
        bit_valid = 1'b0;
        test_reset();
        test_basic();
        test_bad_parity();
        test_stall();
        test_start_busy();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_parity_checker.md
Name: serial_parity_checker

Overview:
Consumes the 1-bit serial stream produced by the XOR_2x1 stage, one bit per accepted cycle. It frames FRAME_LEN data bits followed by one even-parity bit. It also assembles the data word, checks parity and reports a per-frame error flag. A saturating error counter is provided for lab observation on LEDs or the bench.

Parameters:
FRAME_LEN, 8, number of data bits per frame, legal range 2..16.
CNT_W, 8, width of err_count.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising clk
start  input  1  one-cycle pulse that opens a frame; honoured only in IDLE
bit_in  input  1  serial data bit (XOR_2x1 out)
bit_valid  input  1  bit_in is accepted on this edge when high
busy  output  1  high while a frame is open (state != IDLE)
data_out  output  FRAME_LEN  last assembled data word, MSB = first bit received
frame_done  output  1  one-cycle pulse when a frame completes
parity_err  output  1  result of last completed frame: 1 = parity mismatch
err_count  output  CNT_W  count of frames with parity_err = 1, saturating

Behaviour:
- Reset (rst_n = 0 at a rising edge): state goes to IDLE. busy, frame_done and parity_err = 0. data_out = 0, err_count = 0, and the internal bit counter, shift register and accumulator = 0. Reset has priority over all other inputs, including mid-frame, where the partial frame is discarded with no frame_done.
- FSM states: IDLE, DATA, PARITY.
- IDLE: on start = 1, go to DATA and clear the bit counter, shift register and parity accumulator. bit_valid is ignored in IDLE, including in the same cycle as start; the first data bit is taken on the next accepted edge.
- DATA: on each edge with bit_valid = 1:
  - shift register <= {shift[FRAME_LEN-2:0], bit_in};
  - acc <= acc ^ bit_in;
  - cnt <= cnt + 1.
  - When cnt == FRAME_LEN-1 and bit_valid = 1, the last data bit is taken and the state goes to PARITY.
  - bit_valid = 0 stalls: state and all registers hold, with no timeout.
- PARITY: on bit_valid = 1, registered on that edge:
  - parity_err <= acc ^ bit_in (even parity over data plus parity bit);
  - data_out <= shift register;
  - frame_done <= 1;
  - err_count increments when acc ^ bit_in = 1, unless it is already at 2^CNT_W-1, where it holds;
  - state returns to IDLE.
  - With bit_valid = 0 the state holds.
- Latency: frame_done, parity_err and data_out become visible in the cycle after the edge that accepted the parity bit.
- frame_done is high for exactly one cycle. parity_err and data_out hold until the next frame completes.
- start while busy = 1 is ignored and does not restart the frame.
- A start pulse in the same cycle that frame_done is high is legal and opens a new frame, because the state is already IDLE.
- busy is registered: it is 1 from the cycle after start is accepted until the cycle frame_done is high, and 0 from then on.
- data_out is not updated mid-frame; only completed frames are published.

Optional Feature:
Macro PARITY_ERR_COUNT_EN.
- Defined: err_count is implemented as described (saturating, CNT_W bits).
- Not defined: no counter flops are built, err_count is tied to 0, and all other behaviour is identical.

Test Plan:
- Frame 1: rst_n = 0 for 2 cycles, then start. Drive bits 1,0,1,0,0,1,0,1 then parity bit 0, bit_valid = 1 every cycle.
  Required response: frame_done pulses once, one cycle after the parity bit; data_out = 8'hA5; parity_err = 0; err_count = 0; busy = 0 in the frame_done cycle.
- Frame 2: same data 8'hA5 with parity bit 1.
  Required response: parity_err = 1; err_count = 1; data_out = 8'hA5.
- Stalls: frame 8'h01 with parity 1, bit_valid deasserted for 3 cycles after bit 3 and 2 cycles before the parity bit.
  Required response: identical result to the unstalled frame (data_out = 8'h01, parity_err = 0); frame_done appears exactly one cycle after the parity bit is accepted.
- Start during busy: pulse start again after bit 4 of frame 8'hFF with parity 0.
  Required response: the frame is not restarted; data_out = 8'hFF; parity_err = 0.
- Reset mid-frame: assert rst_n = 0 after bit 5, then run a full frame 8'h3C with parity 0.
  Required response: no frame_done for the aborted frame; outputs cleared during reset; next frame gives data_out = 8'h3C, parity_err = 0, err_count = 0.
- Counter saturation and compile option: with PARITY_ERR_COUNT_EN defined, send 257 bad-parity frames back to back, with start in the frame_done cycle.
  Required response: err_count stops at 255.
  Rebuild without the macro and repeat: err_count stays 0.
